// File: rtl/pp_pipeline_accel_pkg.sv
// Shared types and defaults for the preprocessing-pipeline stream framer.
// Holds the framer FSM states and the beat layout carried through the output slice.
package pp_pipeline_accel_pkg;

  localparam int DATA_W_DEF = 24;
  localparam int DIM_W_DEF  = 11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] data;
    logic                  user;
    logic                  last;
  } beat_t;

endpackage

// File: rtl/pp_pipeline_accel_axis_skid.sv
// Two-entry AXI4-Stream register slice: registered outputs, one beat per cycle,
// and ready toward the producer that depends only on local occupancy.
module pp_pipeline_accel_axis_skid #(
  parameter int W = 26
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         empty
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         push;
  logic         pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign empty     = (count == 2'd0);
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Entries are cleared on reset so sideband bits read as zero until the first beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/pp_pipeline_accel_stream_framer.sv
// Frames a raw pixel stream into one image of height*width beats (TUSER on the first
// pixel, TLAST at each row end) and reports completion over an ap_ctrl_chain handshake.
module pp_pipeline_accel_stream_framer
  import pp_pipeline_accel_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DIM_W  = DIM_W_DEF
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              ap_start,
  input  logic              ap_continue,
  output logic              ap_ready,
  output logic              ap_done,
  output logic              ap_idle,
  input  logic [31:0]       img_height,
  input  logic [31:0]       img_width,
  output logic              dim_err,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tuser,
  output logic              m_axis_tlast
);

  localparam logic [31:0] DIM_MAX = (32'd1 << DIM_W) - 32'd1;

  state_t             state;
  state_t             next_state;
  logic [DIM_W-1:0]   h_lat;
  logic [DIM_W-1:0]   w_lat;
  logic [DIM_W-1:0]   row;
  logic [DIM_W-1:0]   col;
  logic               last_taken;
  logic               accept;
  logic               dims_zero;
  logic               dims_over;
  logic               beat;
  logic               col_end;
  logic               row_end;
  logic               first_px;
  logic               slice_in_ready;
  logic               slice_empty;
  logic [DATA_W+1:0]  slice_out;

  assign accept    = (state == IDLE) && ap_start;
  assign dims_zero = (img_height == 32'd0) || (img_width == 32'd0);
  assign dims_over = (img_height > DIM_MAX) || (img_width > DIM_MAX);
  assign col_end   = (col == w_lat - DIM_W'(1));
  assign row_end   = (row == h_lat - DIM_W'(1));
  assign first_px  = (row == '0) && (col == '0);
  assign beat      = s_axis_tvalid & s_axis_tready;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // RUN ends only once the final beat has left the slice, so done never precedes data.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (ap_start)                   next_state = (dims_zero || dims_over) ? HOLD : RUN;
      RUN:  if (last_taken && slice_empty)  next_state = HOLD;
      HOLD: if (ap_continue)                next_state = IDLE;
      default:                              next_state = IDLE;
    endcase
  end

  always_comb begin
    ap_ready      = accept;
    ap_idle       = (state == IDLE) && !ap_start;
    ap_done       = (state == HOLD);
    s_axis_tready = (state == RUN) && slice_in_ready && !last_taken;
  end

  // Dimensions are truncated to DIM_W bits once the full-width limit check has passed.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      h_lat      <= '0;
      w_lat      <= '0;
      row        <= '0;
      col        <= '0;
      last_taken <= 1'b0;
      dim_err    <= 1'b0;
    end else if (accept) begin
      h_lat      <= img_height[DIM_W-1:0];
      w_lat      <= img_width[DIM_W-1:0];
      row        <= '0;
      col        <= '0;
      last_taken <= 1'b0;
      dim_err    <= dims_over;
    end else if (beat) begin
      if (col_end) begin
        col <= '0;
        row <= row + DIM_W'(1);
        if (row_end) begin
          last_taken <= 1'b1;
        end
      end else begin
        col <= col + DIM_W'(1);
      end
    end
  end

  pp_pipeline_accel_axis_skid #(
    .W (DATA_W + 2)
  ) u_skid (
    .clk       (ap_clk),
    .rst_n     (ap_rst_n),
    .in_data   ({s_axis_tdata, first_px, col_end}),
    .in_valid  (beat),
    .in_ready  (slice_in_ready),
    .out_data  (slice_out),
    .out_valid (m_axis_tvalid),
    .out_ready (m_axis_tready),
    .empty     (slice_empty)
  );

  assign m_axis_tdata = slice_out[DATA_W+1:2];
  assign m_axis_tuser = slice_out[1];
  assign m_axis_tlast = slice_out[0];

endmodule

// File: tb/tb_pp_pipeline_accel_stream_framer.sv
// Randomised bench for the stream framer: a beat-index reference model predicts every
// output beat, slice occupancy and input readiness, plus literal pins per scenario.
module tb_pp_pipeline_accel_stream_framer;
  import pp_pipeline_accel_pkg::beat_t;

  localparam int DATA_W = 24;
  localparam int DIM_W  = 11;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ap_start = 1'b0;
  logic              ap_continue = 1'b0;
  logic              ap_ready, ap_done, ap_idle, dim_err;
  logic [31:0]       img_height = 32'd0;
  logic [31:0]       img_width = 32'd0;
  logic [DATA_W-1:0] s_tdata = '0;
  logic              s_tvalid = 1'b0;
  logic              s_tready;
  logic [DATA_W-1:0] m_tdata;
  logic              m_tvalid, m_tuser, m_tlast;
  logic              m_tready = 1'b0;

  int checks = 0;
  int errors = 0;

  beat_t exp_q[$];
  beat_t pop_b;
  beat_t new_b;
  int    frame_total = 0, frame_w = 1, accepted = 0, pops = 0;
  int    cyc = 0, last_pop_cyc = 0, saw_full = 0;
  bit    run_phase = 0, prev_stall = 0, s_xfer = 0, legal;
  logic [DATA_W+1:0] prev_out = '0;
  logic  out_user [64];
  logic  out_last [64];
  int    m_mode = 0, valid_pct = 100;
  bit    drv_en = 0;

  always #5 clk = ~clk;

  pp_pipeline_accel_stream_framer #(.DATA_W(DATA_W), .DIM_W(DIM_W)) dut (
    .ap_clk        (clk),
    .ap_rst_n      (rst_n),
    .ap_start      (ap_start),
    .ap_continue   (ap_continue),
    .ap_ready      (ap_ready),
    .ap_done       (ap_done),
    .ap_idle       (ap_idle),
    .img_height    (img_height),
    .img_width     (img_width),
    .dim_err       (dim_err),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tuser  (m_tuser),
    .m_axis_tlast  (m_tlast)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: beat k of a frame carries user=(k==0) and last=(k%w==w-1).
  always @(negedge clk) begin
    cyc++;
    s_xfer = s_tvalid && s_tready;
    if (rst_n) begin
      checkOutput("m_valid", m_tvalid, exp_q.size() != 0);
      if (m_tvalid && exp_q.size() != 0) begin
        checkOutput("m_data", m_tdata, exp_q[0].data);
        checkOutput("m_user", m_tuser, exp_q[0].user);
        checkOutput("m_last", m_tlast, exp_q[0].last);
      end
      if (prev_stall && m_tvalid)
        checkOutput("stall_stable", {m_tdata, m_tuser, m_tlast}, prev_out);
      checkOutput("s_ready", s_tready, run_phase && exp_q.size() < 2 && accepted < frame_total);
      if (ap_ready) checkOutput("ready_not_in_hold", ap_done, 1'b0);
      if (exp_q.size() == 2) saw_full++;
      prev_stall = m_tvalid && !m_tready;
      prev_out   = {m_tdata, m_tuser, m_tlast};
      if (m_tvalid && m_tready && exp_q.size() != 0) begin
        pop_b = exp_q.pop_front();
        if (pops < 64) begin
          out_user[pops] = m_tuser;
          out_last[pops] = m_tlast;
        end
        pops++;
        last_pop_cyc = cyc;
      end
      if (s_xfer) begin
        new_b.data = s_tdata;
        new_b.user = (accepted == 0);
        new_b.last = ((accepted % frame_w) == frame_w - 1);
        exp_q.push_back(new_b);
        accepted++;
      end
      if (ap_ready) begin
        legal = img_height >= 1 && img_height <= 2047 && img_width >= 1 && img_width <= 2047;
        frame_w     = legal ? int'(img_width) : 1;
        frame_total = legal ? int'(img_height) * int'(img_width) : 0;
        accepted    = 0;
        pops        = 0;
        run_phase   = legal;
      end
      if (ap_done) run_phase = 0;
    end else begin
      prev_stall = 0;
    end
  end

  // AXI-compliant source: a pending beat is held until it transfers.
  always @(posedge clk) begin
    #1;
    if (!s_tvalid || s_xfer) begin
      s_tvalid = drv_en && ($urandom_range(99) < valid_pct);
      s_tdata  = DATA_W'($urandom);
    end
    case (m_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = ~m_tready;
      default: m_tready = 1'($urandom_range(1));
    endcase
  end

  task automatic applyStimulus(input int h, input int w);
    int n;
    img_height = 32'(h);
    img_width  = 32'(w);
    ap_start   = 1'b1;
    n = 0;
    @(negedge clk);
    while (!ap_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("ap_ready_seen", ap_ready, 1'b1);
    @(posedge clk);
    #1 ap_start = 1'b0;
  endtask

  task automatic waitDone(input int limit);
    int n;
    n = 0;
    @(negedge clk);
    while (!ap_done && n < limit) begin
      @(negedge clk);
      n++;
    end
    checkOutput("done_seen", ap_done, 1'b1);
    #1;
  endtask

  task automatic releaseDone();
    @(posedge clk);
    #1 ap_continue = 1'b1;
    @(posedge clk);
    #1 ap_continue = 1'b0;
    checkOutput("idle_after_continue", ap_idle, 1'b1);
    checkOutput("done_cleared", ap_done, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    #12;
    checkOutput("rst_idle", ap_idle, 1'b1);
    checkOutput("rst_ready", ap_ready, 1'b0);
    checkOutput("rst_done", ap_done, 1'b0);
    checkOutput("rst_dim_err", dim_err, 1'b0);
    checkOutput("rst_s_ready", s_tready, 1'b0);
    checkOutput("rst_m_valid", m_tvalid, 1'b0);
    checkOutput("rst_m_user", m_tuser, 1'b0);
    checkOutput("rst_m_last", m_tlast, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    drv_en = 1;

    $display("[TB] 4x3 frame, sink always ready");
    @(posedge clk); #1;
    applyStimulus(3, 4);
    waitDone(500);
    checkOutput("beats_4x3", pops, 12);
    checkOutput("done_gap", cyc - last_pop_cyc, 2);
    checkOutput("pin_user0", out_user[0], 1'b1);
    checkOutput("pin_user1", out_user[1], 1'b0);
    checkOutput("pin_last2", out_last[2], 1'b0);
    checkOutput("pin_last3", out_last[3], 1'b1);
    checkOutput("pin_last7", out_last[7], 1'b1);
    checkOutput("pin_last11", out_last[11], 1'b1);
    releaseDone();

    $display("[TB] 4x3 frame, sink toggling");
    m_mode = 1;
    saw_full = 0;
    @(posedge clk); #1;
    applyStimulus(3, 4);
    waitDone(500);
    checkOutput("beats_toggle", pops, 12);
    checkOutput("slice_filled", saw_full > 0, 1'b1);
    releaseDone();

    $display("[TB] 1x1 frame, continue held low");
    m_mode = 2;
    valid_pct = 60;
    @(posedge clk); #1;
    applyStimulus(1, 1);
    waitDone(500);
    checkOutput("beats_1x1", pops, 1);
    checkOutput("pin_1x1_user", out_user[0], 1'b1);
    checkOutput("pin_1x1_last", out_last[0], 1'b1);
    repeat (4) begin
      @(negedge clk);
      checkOutput("done_held", ap_done, 1'b1);
    end
    releaseDone();

    $display("[TB] zero width and oversize width");
    @(posedge clk); #1;
    applyStimulus(3, 0);
    checkOutput("zero_done", ap_done, 1'b1);
    checkOutput("zero_m_valid", m_tvalid, 1'b0);
    checkOutput("zero_dim_err", dim_err, 1'b0);
    releaseDone();
    @(posedge clk); #1;
    applyStimulus(3, 2048);
    checkOutput("over_done", ap_done, 1'b1);
    checkOutput("over_m_valid", m_tvalid, 1'b0);
    checkOutput("over_dim_err", dim_err, 1'b1);
    releaseDone();

    $display("[TB] 3x5 random frame clears dim_err");
    @(posedge clk); #1;
    applyStimulus(5, 3);
    checkOutput("dim_err_cleared", dim_err, 1'b0);
    waitDone(1000);
    checkOutput("beats_3x5", pops, 15);
    releaseDone();

    $display("[TB] reset mid-frame");
    m_mode = 0;
    valid_pct = 100;
    @(posedge clk); #1;
    applyStimulus(3, 4);
    for (int n = 0; n < 200 && pops < 5; n++) begin
      @(negedge clk);
      #1;
    end
    checkOutput("reached_beat5", pops >= 5, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_m_valid", m_tvalid, 1'b0);
    checkOutput("mid_rst_s_ready", s_tready, 1'b0);
    checkOutput("mid_rst_done", ap_done, 1'b0);
    checkOutput("mid_rst_idle", ap_idle, 1'b1);
    checkOutput("mid_rst_user", m_tuser, 1'b0);
    checkOutput("mid_rst_last", m_tlast, 1'b0);
    exp_q.delete();
    run_phase = 0;
    frame_total = 0;
    accepted = 0;
    pops = 0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(2, 2);
    waitDone(500);
    checkOutput("beats_2x2", pops, 4);
    checkOutput("pin_2x2_user0", out_user[0], 1'b1);
    checkOutput("pin_2x2_last0", out_last[0], 1'b0);
    checkOutput("pin_2x2_last1", out_last[1], 1'b1);
    checkOutput("pin_2x2_last3", out_last[3], 1'b1);
    releaseDone();

    $display("[TB] back-to-back frames, continue tied high");
    m_mode = 2;
    ap_continue = 1'b1;
    @(posedge clk); #1;
    applyStimulus(2, 2);
    waitDone(500);
    checkOutput("b2b_first_beats", pops, 4);
    img_height = 32'd1;
    img_width  = 32'd3;
    ap_start   = 1'b1;
    #0;
    checkOutput("b2b_in_hold", ap_done, 1'b1);
    checkOutput("b2b_no_early_ready", ap_ready, 1'b0);
    applyStimulus(1, 3);
    waitDone(500);
    checkOutput("b2b_second_beats", pops, 3);
    checkOutput("pin_3x1_user0", out_user[0], 1'b1);
    checkOutput("pin_3x1_user1", out_user[1], 1'b0);
    checkOutput("pin_3x1_last1", out_last[1], 1'b0);
    checkOutput("pin_3x1_last2", out_last[2], 1'b1);
    @(posedge clk);
    #1 ap_continue = 1'b0;
    checkOutput("b2b_idle", ap_idle, 1'b1);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
